// File: rtl/aes128_key_schedule.sv
// AES-128 key expansion engine: expands an accepted cipher key into round keys
// 0..10 at one round per clock and serves them through a combinational read port.
module aes128_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         schedule_done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  generate
    if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes128_key_schedule supports only NUM_ROUNDS = 10");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [3:0]   r_cnt;
  logic [127:0] r_slot [0:10];
  logic         w_accept;
  logic [127:0] w_prevKey;
  logic [127:0] w_newKey;
  logic [31:0]  w_rotWord;
  logic [31:0]  w_subWord;
  logic [31:0]  w_g;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Handshake outputs are forced low while reset is held, independent of state.
  always_comb begin
    w_nextState   = r_state;
    w_accept      = 1'b0;
    key_ready     = 1'b0;
    busy          = 1'b0;
    schedule_done = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          key_ready = 1'b1;
          if (key_valid) begin
            w_accept    = 1'b1;
            w_nextState = EXPAND;
          end
        end
        EXPAND: begin
          busy = 1'b1;
          if (r_cnt == LAST_ROUND) w_nextState = DONE;
        end
        DONE: begin
          key_ready     = 1'b1;
          schedule_done = 1'b1;
          if (key_valid) begin
            w_accept    = 1'b1;
            w_nextState = EXPAND;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      for (int i = 0; i <= 10; i++) r_slot[i] <= '0;
    end else if (w_accept) begin
      r_slot[0] <= key_in;
      r_cnt     <= 4'd1;
    end else if (r_state == EXPAND) begin
      for (int i = 1; i <= 10; i++) begin
        if (r_cnt == 4'(i)) r_slot[i] <= w_newKey;
      end
      if (r_cnt != LAST_ROUND) r_cnt <= r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_prevKey = '0;
    for (int i = 1; i <= 10; i++) begin
      if (r_cnt == 4'(i)) w_prevKey = r_slot[i-1];
    end
  end

  assign w_rotWord = {w_prevKey[23:0], w_prevKey[31:24]};
  assign w_subWord = {sbox(w_rotWord[31:24]), sbox(w_rotWord[23:16]),
                      sbox(w_rotWord[15:8]),  sbox(w_rotWord[7:0])};
  assign w_g       = w_subWord ^ {rcon(r_cnt), 24'h000000};
  assign w_n0      = w_prevKey[127:96] ^ w_g;
  assign w_n1      = w_n0 ^ w_prevKey[95:64];
  assign w_n2      = w_n1 ^ w_prevKey[63:32];
  assign w_n3      = w_n2 ^ w_prevKey[31:0];
  assign w_newKey  = {w_n0, w_n1, w_n2, w_n3};

  // Indices 11..15 have no slot behind them and read as zero.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rd_idx == 4'(i)) rd_key = r_slot[i];
    end
  end

endmodule
